// File: rtl/plot_sequencer.sv
// Column-by-column function plotter: samples f(x) every X_STEP pixels, maps the value to a clamped
// screen Y and hands segments between consecutive points to the line drawer. Option: PLOT_SEQUENCER_PEN_LIFT_EN.
module plot_sequencer #(
    parameter int unsigned HOR_ACTIVE_PIXELS     = 640,
    parameter int unsigned VER_ACTIVE_PIXELS     = 480,
    parameter int unsigned X_STEP                = 8,
    parameter int unsigned INTEGER_PART_WIDTH    = 8,
    parameter int unsigned FRACTIONAL_PART_WIDTH = 8,
    parameter int unsigned Y_SCALE_LOG2          = 5,
    localparam int unsigned X_WIDTH     = $clog2(HOR_ACTIVE_PIXELS),
    localparam int unsigned Y_WIDTH     = $clog2(VER_ACTIVE_PIXELS),
    localparam int unsigned VALUE_WIDTH = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   ready,
    output logic                   done,
    output logic                   sample_req,
    output logic [X_WIDTH-1:0]     sample_x,
    input  logic [VALUE_WIDTH-1:0] sample_value,
    input  logic                   sample_error,
    input  logic                   sample_valid,
    output logic [X_WIDTH-1:0]     x1,
    output logic [Y_WIDTH-1:0]     y1,
    output logic [X_WIDTH-1:0]     x2,
    output logic [Y_WIDTH-1:0]     y2,
    output logic                   line_drawer_start,
    input  logic                   line_drawer_ready
);

    localparam int unsigned SHIFT  = FRACTIONAL_PART_WIDTH - Y_SCALE_LOG2;
    localparam int unsigned IW     = VALUE_WIDTH + 2;
    localparam int unsigned LAST_X = ((HOR_ACTIVE_PIXELS - 1) / X_STEP) * X_STEP;
    localparam int unsigned Y_MID  = VER_ACTIVE_PIXELS / 2;
    localparam int unsigned Y_MAX  = VER_ACTIVE_PIXELS - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DRAW,
        S_WAIT_LD_1,
        S_WAIT_LD_2,
        S_NEXT
    } state_t;

    state_t               state;
    logic [Y_WIDTH-1:0]   cur_y;
    logic                 cur_drawable;
    logic [X_WIDTH-1:0]   prev_x;
    logic [Y_WIDTH-1:0]   prev_y;
    logic                 prev_valid;

    logic signed [IW-1:0] value_ext_c;
    logic signed [IW-1:0] off_c;
    logic signed [IW-1:0] y_full_c;
    logic [Y_WIDTH-1:0]   y_c;
    logic                 drawable_c;

    // Fixed-point value to screen row: Y grows downward from the vertical centre.
    always_comb begin
        value_ext_c = $signed({{2{sample_value[VALUE_WIDTH-1]}}, sample_value});
        off_c       = value_ext_c >>> SHIFT;
        y_full_c    = $signed(IW'(Y_MID)) - off_c;
        y_c         = Y_WIDTH'(y_full_c);
        if (y_full_c[IW-1]) begin
            y_c = '0;
        end else if (y_full_c > $signed(IW'(Y_MAX))) begin
            y_c = Y_WIDTH'(Y_MAX);
        end
    end

`ifdef PLOT_SEQUENCER_PEN_LIFT_EN
    assign drawable_c = ~sample_error;
`else
    logic unused_sample_error;
    assign unused_sample_error = sample_error;
    assign drawable_c          = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            ready             <= 1'b1;
            done              <= 1'b0;
            sample_req        <= 1'b0;
            sample_x          <= '0;
            x1                <= '0;
            y1                <= '0;
            x2                <= '0;
            y2                <= '0;
            line_drawer_start <= 1'b0;
            cur_y             <= '0;
            cur_drawable      <= 1'b0;
            prev_x            <= '0;
            prev_y            <= '0;
            prev_valid        <= 1'b0;
        end else begin
            done              <= 1'b0;
            line_drawer_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ready      <= 1'b0;
                        sample_req <= 1'b1;
                        sample_x   <= '0;
                        prev_valid <= 1'b0;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (sample_valid) begin
                        cur_y        <= y_c;
                        cur_drawable <= drawable_c;
                        sample_req   <= 1'b0;
                        state        <= S_DRAW;
                    end
                end
                // sample_x still holds the current column here
                S_DRAW: begin
                    if (prev_valid && cur_drawable) begin
                        x1                <= prev_x;
                        y1                <= prev_y;
                        x2                <= sample_x;
                        y2                <= cur_y;
                        line_drawer_start <= 1'b1;
                        state             <= S_WAIT_LD_1;
                    end else begin
                        state <= S_NEXT;
                    end
                    prev_x     <= sample_x;
                    prev_y     <= cur_y;
                    prev_valid <= cur_drawable;
                end
                // drawer's ready is not trusted in the cycle right after the start pulse
                S_WAIT_LD_1: state <= S_WAIT_LD_2;
                S_WAIT_LD_2: begin
                    if (line_drawer_ready) begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (sample_x == X_WIDTH'(LAST_X)) begin
                        done  <= 1'b1;
                        ready <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        sample_x   <= sample_x + X_WIDTH'(X_STEP);
                        sample_req <= 1'b1;
                        state      <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_plot_sequencer.sv
// Directed bench for plot_sequencer on a 64-pixel-wide screen with 16-pixel columns;
// the bench plays both the sample source and the line drawer.
module tb_plot_sequencer;

    localparam int unsigned HOR = 64;
    localparam int unsigned VER = 480;
    localparam int unsigned XS  = 16;
    localparam int unsigned VW  = 17;
    localparam int unsigned XW  = $clog2(HOR);
    localparam int unsigned YW  = $clog2(VER);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          ready;
    logic          done;
    logic          sample_req;
    logic [XW-1:0] sample_x;
    logic [VW-1:0] sample_value;
    logic          sample_error;
    logic          sample_valid;
    logic [XW-1:0] x1;
    logic [YW-1:0] y1;
    logic [XW-1:0] x2;
    logic [YW-1:0] y2;
    logic          line_drawer_start;
    logic          line_drawer_ready;

    int checks = 0;
    int errors = 0;

    int            seg_n;
    int            done_n;
    int            samp_n;
    bit            extra_start;
    bit            stable;
    logic [XW-1:0] samp_x  [0:7];
    logic [XW-1:0] sg_x1   [0:7];
    logic [YW-1:0] sg_y1   [0:7];
    logic [XW-1:0] sg_x2   [0:7];
    logic [YW-1:0] sg_y2   [0:7];

    plot_sequencer #(
        .HOR_ACTIVE_PIXELS(HOR),
        .VER_ACTIVE_PIXELS(VER),
        .X_STEP(XS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .ready(ready),
        .done(done),
        .sample_req(sample_req),
        .sample_x(sample_x),
        .sample_value(sample_value),
        .sample_error(sample_error),
        .sample_valid(sample_valid),
        .x1(x1),
        .y1(y1),
        .x2(x2),
        .y2(y2),
        .line_drawer_start(line_drawer_start),
        .line_drawer_ready(line_drawer_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full plot; inputs change and outputs are observed on the falling edge.
    task automatic run_plot(input logic [VW-1:0] val, input int err_x, input bit mid_start,
                            input bit hold_valid, input bit stall);
        int cyc = 0;
        int hold = 0;
        bit fin = 1'b0;
        bit pulsed = 1'b0;
        logic [XW-1:0] hx1, hx2;
        logic [YW-1:0] hy1, hy2;
        seg_n = 0; done_n = 0; samp_n = 0; extra_start = 1'b0; stable = 1'b1;
        hx1 = '0; hx2 = '0; hy1 = '0; hy2 = '0;
        sample_value = val;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("first_req_latency", sample_req, 1);
        chk("first_sample_x", sample_x, 0);
        chk("busy_not_ready", ready, 0);
        while (!fin && cyc < 2000) begin
            if (line_drawer_start) begin
                if (hold > 0) extra_start = 1'b1;
                if (seg_n < 8) begin
                    sg_x1[seg_n] = x1; sg_y1[seg_n] = y1;
                    sg_x2[seg_n] = x2; sg_y2[seg_n] = y2;
                end
                seg_n++;
                if (stall && seg_n == 1) begin
                    hold = 20; hx1 = x1; hy1 = y1; hx2 = x2; hy2 = y2;
                end
            end else if (hold > 0) begin
                if (x1 !== hx1 || y1 !== hy1 || x2 !== hx2 || y2 !== hy2) stable = 1'b0;
            end
            if (done) begin
                done_n++;
                fin = 1'b1;
            end
            if (sample_req) begin
                if (samp_n < 8) samp_x[samp_n] = sample_x;
                samp_n++;
            end
            start = 1'b0;
            if (mid_start && !pulsed && sample_req && sample_x == XW'(16)) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            sample_valid      = sample_req ? 1'b1 : hold_valid;
            sample_error      = (int'(sample_x) == err_x);
            line_drawer_ready = (hold == 0);
            if (hold > 0) hold--;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; sample_valid = 1'b0; sample_error = 1'b0; line_drawer_ready = 1'b1;
        chk("plot_finished", 32'(fin), 1);
        chk("done_is_pulse", done, 0);
        chk("ready_after_plot", ready, 1);
    endtask

    initial begin
        bit seen;
        bit quiet;
        int cyc;
        rst_n = 1'b0; start = 1'b0; sample_valid = 1'b0; sample_error = 1'b0;
        sample_value = '0; line_drawer_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_sample_req", sample_req, 0);
        chk("rst_sample_x", sample_x, 0);
        chk("rst_x1", x1, 0);
        chk("rst_y1", y1, 0);
        chk("rst_x2", x2, 0);
        chk("rst_y2", y2, 0);
        chk("rst_ld_start", line_drawer_start, 0);
        rst_n = 1'b1;

        // all-zero function: flat line through the centre row
        run_plot(VW'(0), -1, 1'b0, 1'b0, 1'b0);
        chk("t2_samples", samp_n, 4);
        chk("t2_sx1", samp_x[1], 16);
        chk("t2_sx2", samp_x[2], 32);
        chk("t2_sx3", samp_x[3], 48);
        chk("t2_segs", seg_n, 3);
        chk("t2_done_n", done_n, 1);
        chk("t2_s0_x1", sg_x1[0], 0);
        chk("t2_s0_y1", sg_y1[0], 240);
        chk("t2_s0_x2", sg_x2[0], 16);
        chk("t2_s0_y2", sg_y2[0], 240);
        chk("t2_s1_x1", sg_x1[1], 16);
        chk("t2_s1_x2", sg_x2[1], 32);
        chk("t2_s2_x1", sg_x1[2], 32);
        chk("t2_s2_x2", sg_x2[2], 48);
        chk("t2_s2_y2", sg_y2[2], 240);

        // Y mapping: +1.0, +127.0 (clamp top), -128.0 (clamp bottom), -1/256, +7.03125
        run_plot(17'h00100, -1, 1'b0, 1'b0, 1'b0);
        chk("t3_y1", sg_y1[0], 208);
        chk("t3_y2", sg_y2[0], 208);
        run_plot(17'h07F00, -1, 1'b0, 1'b0, 1'b0);
        chk("t4_y_clamp_top", sg_y1[0], 0);
        run_plot(17'h18000, -1, 1'b0, 1'b0, 1'b0);
        chk("t5_y_clamp_bot", sg_y2[1], 479);
        run_plot(17'h1FFFF, -1, 1'b0, 1'b0, 1'b0);
        chk("tneg_small_y", sg_y1[0], 241);
        run_plot(17'h00708, -1, 1'b0, 1'b0, 1'b0);
        chk("tpos_y", sg_y2[0], 15);

        // undefined sample at x=16
        run_plot(VW'(0), 16, 1'b0, 1'b0, 1'b0);
`ifdef PLOT_SEQUENCER_PEN_LIFT_EN
        chk("t6_segs_lift", seg_n, 1);
        chk("t6_x1_lift", sg_x1[0], 32);
        chk("t6_x2_lift", sg_x2[0], 48);
`else
        chk("t6_segs_nolift", seg_n, 3);
        chk("t6_s1_x1", sg_x1[1], 16);
`endif

        // start during REQ, sample_valid held high, drawer stalled 20 cycles
        run_plot(17'h00100, -1, 1'b1, 1'b1, 1'b1);
        chk("t7_samples", samp_n, 4);
        chk("t7_sx2", samp_x[2], 32);
        chk("t7_sx3", samp_x[3], 48);
        chk("t7_segs", seg_n, 3);
        chk("t7_done_n", done_n, 1);
        chk("t7_stable", 32'(stable), 1);
        chk("t7_no_extra_start", 32'(extra_start), 0);

        // reset while waiting on the line drawer
        sample_value = '0;
        seen = 1'b0;
        cyc = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!seen && cyc < 200) begin
            sample_valid = sample_req;
            if (line_drawer_start) begin
                seen = 1'b1;
                line_drawer_ready = 1'b0;
                sample_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("t1_seg_seen", 32'(seen), 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        line_drawer_ready = 1'b1;
        chk("t1_ready", ready, 1);
        chk("t1_ld_start", line_drawer_start, 0);
        chk("t1_sample_req", sample_req, 0);
        chk("t1_x1", x1, 0);
        chk("t1_y1", y1, 0);
        chk("t1_x2", x2, 0);
        chk("t1_y2", y2, 0);
        quiet = 1'b1;
        repeat (30) begin
            sample_valid = 1'b1;
            @(negedge clk);
            if (line_drawer_start || sample_req || done) quiet = 1'b0;
        end
        sample_valid = 1'b0;
        chk("t1_aborted_quiet", 32'(quiet), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
